// File: rtl/spk_pkg.sv
// Shared types and reset values for the speaker scheduler: FSM state
// encoding plus a width helper used to size counters and indices.
package spk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } spk_state_e;

    localparam spk_state_e RST_STATE = ST_IDLE;
    localparam logic       RST_BIT   = 1'b0;

    // $clog2 that never yields a zero-width vector
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 32'd1) ? $clog2(v) : 32'd1;
    endfunction

endpackage

// File: rtl/spk_beat_timer.sv
// Free-running cycle counter with a run-time terminal count; times beats
// in PLAY and the articulation gap in GAP.
module spk_beat_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == term_i);

    // Count up, wrapping to zero on the terminal count or on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i || tick_o) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/speaker_scheduler.sv
// Fixed-priority sharing of one tone generator among N_REQ note requesters.
// Define SPK_PREEMPT_EN to let a higher-priority request abort the current note.
module speaker_scheduler
    import spk_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned DIV_W    = 20,
    parameter int unsigned DUR_W    = 4,
    parameter int unsigned BEAT_CYC = 12500000,
    parameter int unsigned GAP_CYC  = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DIV_W-1:0]        note_div,
    input  logic [N_REQ*DUR_W-1:0]        dur,
    input  logic                          flush,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              done,
    output logic [DIV_W-1:0]              tone_div,
    output logic                          tone_en,
    output logic                          busy,
    output logic [clog2_min1(N_REQ)-1:0]  grant_id
);

    localparam int unsigned GID_W = clog2_min1(N_REQ);
    localparam int unsigned MAX_C = (BEAT_CYC > GAP_CYC) ? BEAT_CYC : GAP_CYC;
    localparam int unsigned TW    = clog2_min1(MAX_C);
    localparam logic [TW-1:0] BEAT_TERM = TW'(BEAT_CYC - 32'd1);
    localparam logic [TW-1:0] GAP_TERM  = TW'((GAP_CYC > 32'd0) ? (GAP_CYC - 32'd1) : 32'd0);
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    spk_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [GID_W-1:0]  gid_q, gid_d;
    logic [N_REQ-1:0]  ack_q, ack_d, done_q, done_d;
    logic [DIV_W-1:0]  tone_div_q, tone_div_d;
    logic              tone_en_q, tone_en_d, busy_q, busy_d;
    logic              sel_vld_s, preempt_s, restart_s, clr_s, tick_s;
    logic [GID_W-1:0]  sel_idx_s;
    logic [DIV_W-1:0]  sel_div_s;
    logic [DUR_W-1:0]  sel_dur_s, raw_dur_s;
    logic [TW-1:0]     term_s;

    // Lowest set request index wins; its note is what would be latched
    always_comb begin
        sel_vld_s = |req;
        sel_idx_s = {GID_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel_idx_s = req[i] ? GID_W'(i) : sel_idx_s;
        end
        sel_div_s = note_div[int'(sel_idx_s)*DIV_W +: DIV_W];
        raw_dur_s = dur[int'(sel_idx_s)*DUR_W +: DUR_W];
        sel_dur_s = (raw_dur_s == {DUR_W{1'b0}}) ? DUR_ONE : raw_dur_s;
`ifdef SPK_PREEMPT_EN
        preempt_s = sel_vld_s && (state_q != ST_IDLE) && (sel_idx_s < gid_q);
`else
        preempt_s = 1'b0;
`endif
    end

    // Next-state, note latching and registered-output values
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rem_d     = rem_q;
        gid_d     = gid_q;
        ack_d     = {N_REQ{1'b0}};
        done_d    = {N_REQ{1'b0}};
        restart_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld_s) begin
                    state_d          = ST_PLAY;
                    div_d            = sel_div_s;
                    rem_d            = sel_dur_s;
                    gid_d            = sel_idx_s;
                    ack_d[sel_idx_s] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (tick_s && (rem_q == DUR_ONE)) begin
                    done_d[gid_q] = 1'b1;
                    state_d       = (GAP_CYC > 32'd0) ? ST_GAP : ST_IDLE;
                end else if (tick_s) begin
                    rem_d = rem_q - DUR_ONE;
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flush beats everything, including a same-cycle selection
        if (flush) begin
            state_d = ST_IDLE;
            div_d   = div_q;
            rem_d   = rem_q;
            gid_d   = gid_q;
            ack_d   = {N_REQ{1'b0}};
            done_d  = {N_REQ{1'b0}};
        end else if (preempt_s) begin
            state_d          = ST_PLAY;
            div_d            = sel_div_s;
            rem_d            = sel_dur_s;
            gid_d            = sel_idx_s;
            ack_d            = {N_REQ{1'b0}};
            ack_d[sel_idx_s] = 1'b1;
            done_d           = {N_REQ{1'b0}};
            restart_s        = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
        tone_div_d = (state_d == ST_PLAY) ? div_d : {DIV_W{1'b0}};
        tone_en_d  = (state_d == ST_PLAY) && (div_d != {DIV_W{1'b0}});
        busy_d     = (state_d != ST_IDLE);
    end

    assign clr_s  = (state_q == ST_IDLE) || (state_d != state_q) || restart_s;
    assign term_s = (state_q == ST_GAP) ? GAP_TERM : BEAT_TERM;

    spk_beat_timer #(.CNT_W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_s),
        .term_i (term_s),
        .tick_o (tick_s)
    );

    // State, latched note and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            div_q      <= {DIV_W{1'b0}};
            rem_q      <= {DUR_W{1'b0}};
            gid_q      <= {GID_W{1'b0}};
            ack_q      <= {N_REQ{1'b0}};
            done_q     <= {N_REQ{1'b0}};
            tone_div_q <= {DIV_W{1'b0}};
            tone_en_q  <= RST_BIT;
            busy_q     <= RST_BIT;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            gid_q      <= gid_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            tone_div_q <= tone_div_d;
            tone_en_q  <= tone_en_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign tone_div = tone_div_q;
    assign tone_en  = tone_en_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_speaker_scheduler.sv
// Self-checking bench for speaker_scheduler: cycle-level note model plus
// directed scenarios and randomized requester traffic.
module tb_speaker_scheduler;

    localparam int N  = 3;
    localparam int DW = 20;
    localparam int UW = 4;
    localparam int BC = 10;
    localparam int GC = 3;
`ifdef SPK_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] note_div;
    logic [N*UW-1:0] dur;
    logic            flush;
    logic [N-1:0]    ack, done;
    logic [DW-1:0]   tone_div;
    logic            tone_en, busy;
    logic [1:0]      grant_id;

    speaker_scheduler #(.N_REQ(N), .DIV_W(DW), .DUR_W(UW), .BEAT_CYC(BC), .GAP_CYC(GC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .note_div(note_div), .dur(dur),
        .flush(flush), .ack(ack), .done(done), .tone_div(tone_div),
        .tone_en(tone_en), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 playing, 2 silent gap; time kept as cycles left
    int            m_mode, m_left, m_gap, m_gid;
    logic [DW-1:0] m_div;
    logic [N-1:0]  e_ack, e_done;
    int            n_chk = 0, n_fail = 0;
    bit            auto_drop;
    int            o_tone, o_busy, o_done, o_ack;
    logic [DW-1:0] o_div;
    int            ack_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int low_idx(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_gap = 0; m_gid = 0; m_div = '0;
        e_ack = '0; e_done = '0;
    endtask

    task automatic m_start(input int j);
        int d;
        d      = int'(dur[j*UW +: UW]);
        m_mode = 1;
        m_div  = note_div[j*DW +: DW];
        m_left = ((d == 0) ? 1 : d) * BC;
        m_gid  = j;
        e_ack[j] = 1'b1;
    endtask

    task automatic m_step();
        int j;
        e_ack = '0; e_done = '0;
        j = low_idx(req);
        if (flush) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (j >= 0) m_start(j);
        end else if (PREEMPT && j >= 0 && j < m_gid) begin
            m_start(j);
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                e_done[m_gid] = 1'b1;
                if (GC > 0) begin m_mode = 2; m_gap = GC; end
                else m_mode = 0;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_mode = 0;
        end
    endtask

    task automatic compare();
        chk("ack", ack, e_ack);
        chk("done", done, e_done);
        chk("tone_div", tone_div, (m_mode == 1) ? m_div : '0);
        chk("tone_en", tone_en, (m_mode == 1) && (m_div != '0));
        chk("busy", busy, m_mode != 0);
        chk("grant_id", grant_id, m_gid);
    endtask

    task automatic clr_obs();
        o_tone = 0; o_busy = 0; o_done = 0; o_ack = 0; o_div = '0;
        ack_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        #1;
        compare();
        if (tone_en) begin o_tone++; o_div = tone_div; end
        if (busy) o_busy++;
        o_done += $countones(done);
        o_ack  += $countones(ack);
        if (|ack) ack_q.push_back(low_idx(ack));
        if (auto_drop) req = req & ~e_ack;
    endtask

    task automatic set_note(input int i, input logic [DW-1:0] d, input logic [UW-1:0] b);
        note_div[i*DW +: DW] = d;
        dur[i*UW +: UW]      = b;
    endtask

    initial begin
        int t, found;
        rst_n = 1'b0; req = '0; note_div = '0; dur = '0; flush = 1'b0;
        auto_drop = 1'b1;
        m_reset(); clr_obs();
        #2 compare();
        @(negedge clk); rst_n = 1'b1;

        // idle, nothing requested
        repeat (50) step();
        chk("idle_busy_cycles", o_busy, 0);

        // single note from requester 1
        set_note(1, 20'h01234, 4'd2); req = 3'b010; clr_obs();
        repeat (40) step();
        chk("r1_ack_count", o_ack, 1);
        chk("r1_tone_cycles", o_tone, 20);
        chk("r1_tone_div", o_div, 20'h01234);
        chk("r1_done_count", o_done, 1);
        chk("r1_busy_cycles", o_busy, 23);

        // simultaneous requests 0 and 2
        set_note(0, 20'h00100, 4'd1); set_note(2, 20'h00300, 4'd1);
        req = 3'b101; clr_obs();
        repeat (40) step();
        chk("prio_ack_count", ack_q.size(), 2);
        if (ack_q.size() == 2) begin
            chk("prio_first", ack_q[0], 0);
            chk("prio_second", ack_q[1], 2);
        end
        chk("prio_tone_cycles", o_tone, 20);

        // rest note with zero duration
        set_note(0, 20'h0, 4'd0); req = 3'b001; clr_obs();
        repeat (25) step();
        chk("rest_tone_cycles", o_tone, 0);
        chk("rest_busy_cycles", o_busy, 13);
        chk("rest_done_count", o_done, 1);

        // higher-priority request arrives mid-note
        set_note(2, 20'h00555, 4'd3); set_note(0, 20'h00111, 4'd1);
        req = 3'b100; clr_obs();
        step();
        chk("pre_ack2", ack, 3'b100);
        repeat (5) step();
        req[0] = 1'b1; found = 0; t = 0;
        while (!found && t < 60) begin
            step(); t++;
            if (ack[0]) found = 1;
        end
        chk("pre_ack0_seen", found, 1);
        chk("pre_ack0_delay", t, PREEMPT ? 1 : 29);
        chk("pre_done2_count", o_done, PREEMPT ? 0 : 1);
        repeat (40) step();

        // flush on the fourth PLAY cycle
        set_note(1, 20'h00abc, 4'd2); req = 3'b010; clr_obs();
        repeat (4) step();
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_tone_en", tone_en, 1'b0);
        chk("flush_busy", busy, 1'b0);
        repeat (25) step();
        chk("flush_done_count", o_done, 0);
        // flush coincident with an idle selection
        set_note(0, 20'h00222, 4'd1); req = 3'b001; flush = 1'b1;
        step(); flush = 1'b0;
        chk("flush_sel_ack", ack, 3'b000);
        repeat (20) step();

        // asynchronous reset in the middle of a note
        set_note(2, 20'h00777, 4'd2); req = 3'b100;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1 m_reset();
        compare();
        chk("rst_tone_en", tone_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        req = '0;

        // randomized requesters, some of which replay after their ack
        auto_drop = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) begin
                    set_note(i, ($urandom_range(0, 3) == 0) ? 20'h0 : DW'($urandom),
                             UW'($urandom_range(0, 3)));
                    req[i] = 1'b1;
                end
            end
            flush = ($urandom_range(0, 99) == 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (e_ack[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
            end
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
